instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Producer side of the instruction interface feeding Control_Logic in the LEGv8 single-cycle datapath.
- Holds the program counter and the instruction memory, and presents the 32-bit instruction for the current PC.
- Computes the next PC from UncondBranch/Branch returned by control and the ALU zero flag.
- Includes a load/run/halt sequencer so benches can preload programs and observe fetch progress.

Parameters:
IMEM_DEPTH, 64, instruction memory depth in 32-bit words (power of 2)
PC_RESET, 64'h0, PC value after reset and while in LOAD
HALT_WORD, 32'hD4400000, encoding that stops fetch (HLT)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  LOAD->RUN request, sampled on clk
stall  input  1  hold PC and counter this cycle
UncondBranch  input  1  from Control_Logic, unconditional branch (B)
Branch  input  1  from Control_Logic, conditional branch (CBZ)
zero  input  1  ALU zero flag for the current instruction
prog_we  input  1  instruction memory write enable, honoured only in LOAD
prog_addr  input  log2(IMEM_DEPTH)  word address for the load
prog_data  input  32  instruction word to load
pc  output  64  current program counter
instruction  output  32  instruction at pc, to Control_Logic and register file
instr_valid  output  1  instruction is a live fetch
halted  output  1  sequencer is in HALT
fetch_count  output  32  instructions retired since reset, saturating

Behaviour:
- Reset (asynchronous, on rst high) forces the following immediately and holds them while rst is high:
  - state=LOAD, pc=PC_RESET, fetch_count=0.
  - instr_valid=0, halted=0.
  - Memory contents are not cleared.
- States: LOAD, RUN, HALT.
- LOAD:
  - When prog_we=1, memory[prog_addr] is written with prog_data on the clk edge.
  - pc holds at PC_RESET; instr_valid=0.
  - start=1 moves the state to RUN on the next edge.
  - start and prog_we in the same cycle: the write completes and the state moves to RUN.
- RUN, combinational fetch:
  - instruction = memory[pc[log2(IMEM_DEPTH)+1:2]] in the same cycle, with zero cycles of latency, as the single-cycle datapath requires.
  - instr_valid=1.
  - prog_we is ignored.
- RUN, next PC, in priority order:
  - UncondBranch=1: pc + (sign_extend(instruction[25:0]) << 2).
  - Otherwise Branch=1 and zero=1: pc + (sign_extend(instruction[23:5]) << 2).
  - Otherwise: pc + 4.
  - Arithmetic is 64-bit modulo 2^64. Offsets are sign-extended to 64 bits before the shift.
- stall=1 in RUN: pc, state and fetch_count hold; instruction stays stable.
- Unstalled RUN edge:
  - fetch_count increments by 1, saturating at 32'hFFFFFFFF.
  - pc loads the next PC.
- Halt conditions, checked in RUN on the current instruction/pc:
  - instruction==HALT_WORD, or
  - pc[1:0]!=0, or
  - pc >= 4*IMEM_DEPTH.
- Any halt condition moves the state to HALT on the next unstalled edge:
  - pc holds (it does not advance).
  - fetch_count counts the HLT as retired.
- Out-of-range or misaligned pc in RUN:
  - instruction is driven 32'h0 and instr_valid=0 that cycle.
  - fetch_count does not increment.
- HALT:
  - halted=1, instr_valid=0; pc, instruction and fetch_count frozen.
  - Only rst leaves HALT; start is ignored.
- rst asserted mid-RUN: everything returns to its reset values asynchronously; the program remains in memory. Deasserting rst and then pulsing start reruns the program.
- Branch/UncondBranch/zero are ignored outside RUN.

Test Plan:
- Load 4 words (ADD, ADD, ADD, HLT) at addresses 0..3, then pulse start -> pc steps 0,4,8,12 on successive edges; halted=1 after the edge at pc=12; fetch_count=4; pc stays 12.
- At pc=0, instruction=32'h14000003 (B +3) with UncondBranch=1 -> next pc=12. At pc=12, instruction B with imm26=26'h3FFFFFE -> next pc=4.
- At pc=8, instruction=32'hB4000060 (CBZ offset +3) with Branch=1: zero=1 -> pc=20; zero=0 -> pc=12.
- Hold stall=1 for 3 cycles at pc=4 -> pc, instruction and fetch_count unchanged. Release -> pc=8 after one edge.
- Branch to pc=4*IMEM_DEPTH -> instruction=0, instr_valid=0, halted=1 next edge, fetch_count not incremented for that pc.
- Assert rst asynchronously mid-cycle during RUN at pc=8 -> pc=0, fetch_count=0, instr_valid=0 without waiting for clk. Pulse prog_we in RUN -> memory unchanged (verify by rerun).

Source files
------------

// File: rtl/instr_fetch_unit.sv
// LEGv8 instruction fetch: PC, instruction memory and a LOAD/RUN/HALT sequencer.
// The fetch path is combinational so the single-cycle datapath sees the word for pc in the same cycle.
module instr_fetch_unit #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [63:0] PC_RESET   = 64'h0,
    parameter logic [31:0] HALT_WORD  = 32'hD4400000,
    localparam int         AW         = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stall,
    input  logic          UncondBranch,
    input  logic          Branch,
    input  logic          zero,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    output logic [63:0]   pc,
    output logic [31:0]   instruction,
    output logic          instr_valid,
    output logic          halted,
    output logic [31:0]   fetch_count
);

    typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_HALT} state_t;

    localparam logic [63:0] PC_LIMIT = 64'(IMEM_DEPTH) << 2;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] mem [IMEM_DEPTH];
    logic [31:0] mem_word;
    logic        pc_in_range;
    logic        halt_cond;
    logic [63:0] off_uncond, off_cond, next_pc;

    // Memory is deliberately outside the reset domain so a program survives rst.
    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_LOAD && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign mem_word    = mem[pc_q[AW+1:2]];
    assign pc_in_range = (pc_q[1:0] == 2'b00) && (pc_q < PC_LIMIT);
    assign instruction = pc_in_range ? mem_word : 32'h0;
    assign halt_cond   = !pc_in_range || (instruction == HALT_WORD);

    assign off_uncond = {{36{instruction[25]}}, instruction[25:0], 2'b00};
    assign off_cond   = {{43{instruction[23]}}, instruction[23:5], 2'b00};

    always_comb begin
        next_pc = pc_q + 64'd4;
        if (UncondBranch) begin
            next_pc = pc_q + off_uncond;
        end else if (Branch && zero) begin
            next_pc = pc_q + off_cond;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        instr_valid   = 1'b0;
        halted        = 1'b0;
        case (state_q)
            ST_LOAD: begin
                pc_d = PC_RESET;
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                instr_valid = pc_in_range;
                if (!stall) begin
                    // A bad pc is not a retired instruction; HLT is.
                    if (pc_in_range && fetch_count_q != 32'hFFFF_FFFF) begin
                        fetch_count_d = fetch_count_q + 32'd1;
                    end
                    if (halt_cond) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_LOAD;
            pc_q          <= PC_RESET;
            fetch_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc          = pc_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table-driven branch/stall trace plus
// hand-written sequences for load, halt, out-of-range and asynchronous reset.
module tb_instr_fetch_unit;

    localparam logic [31:0] W_ADD  = 32'h8B020020;
    localparam logic [31:0] W_HLT  = 32'hD4400000;
    localparam logic [31:0] W_B3   = 32'h14000003;
    localparam logic [31:0] W_BM2  = 32'h17FFFFFE;
    localparam logic [31:0] W_CBZ3 = 32'hB4000060;
    localparam logic [31:0] W_B64  = 32'h14000040;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        ub = 1'b0;
    logic        br = 1'b0;
    logic        zero = 1'b0;
    logic        prog_we = 1'b0;
    logic [5:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic [63:0] pc;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        halted;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall       (stall),
        .UncondBranch(ub),
        .Branch      (br),
        .zero        (zero),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, ub, br, zero;
        logic [63:0] pc_pre;
        logic [31:0] instr_pre;
        logic        valid_pre;
        logic [63:0] pc_post;
        logic [31:0] cnt_post;
        logic        halt_post;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load(input logic [5:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        step();
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0,1'b1,1'b0,1'b0, 64'd0,  W_B3,   1'b1, 64'd12, 32'd1, 1'b0};
        vecs[1]  = '{1'b0,1'b1,1'b1,1'b1, 64'd12, W_BM2,  1'b1, 64'd4,  32'd2, 1'b0};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b0, 64'd4,  W_ADD,  1'b1, 64'd4,  32'd2, 1'b0};
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b0, 64'd4,  W_ADD,  1'b1, 64'd4,  32'd2, 1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b0, 64'd4,  W_ADD,  1'b1, 64'd4,  32'd2, 1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0, 64'd4,  W_ADD,  1'b1, 64'd8,  32'd3, 1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b1,1'b0, 64'd8,  W_CBZ3, 1'b1, 64'd12, 32'd4, 1'b0};
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b0, 64'd12, W_BM2,  1'b1, 64'd4,  32'd5, 1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b1, 64'd4,  W_ADD,  1'b1, 64'd8,  32'd6, 1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b1, 64'd8,  W_CBZ3, 1'b1, 64'd20, 32'd7, 1'b0};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0, 64'd20, W_HLT,  1'b1, 64'd20, 32'd8, 1'b1};
        vecs[11] = '{1'b0,1'b1,1'b1,1'b1, 64'd20, W_HLT,  1'b0, 64'd20, 32'd8, 1'b1};

        // Reset state
        #2;
        do_reset();
        chk("rst_pc", pc, 64'd0);
        chk("rst_cnt", 64'(fetch_count), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);

        // Linear program; HLT written in the same cycle as start
        load(6'd0, W_ADD);
        load(6'd1, W_ADD);
        load(6'd2, W_ADD);
        chk("load_valid", 64'(instr_valid), 64'd0);
        prog_we = 1'b1; prog_addr = 6'd3; prog_data = W_HLT; start = 1'b1;
        step();
        prog_we = 1'b0; start = 1'b0;
        chk("lin_pc0", pc, 64'd0);
        chk("lin_valid0", 64'(instr_valid), 64'd1);
        chk("lin_instr0", 64'(instruction), 64'(W_ADD));
        for (int i = 1; i < 4; i++) begin
            step();
            chk($sformatf("lin_pc%0d", i), pc, 64'(4 * i));
        end
        chk("lin_instr_hlt", 64'(instruction), 64'(W_HLT));
        chk("lin_halted_pre", 64'(halted), 64'd0);
        step();
        chk("lin_halted", 64'(halted), 64'd1);
        chk("lin_cnt", 64'(fetch_count), 64'd4);
        chk("lin_pc_hold", pc, 64'd12);
        chk("lin_valid_halt", 64'(instr_valid), 64'd0);
        pulse_start();
        step();
        chk("halt_start_ignored", 64'(halted), 64'd1);
        chk("halt_pc_frozen", pc, 64'd12);

        // Table-driven branch / stall trace
        do_reset();
        load(6'd0, W_B3);
        load(6'd1, W_ADD);
        load(6'd2, W_CBZ3);
        load(6'd3, W_BM2);
        load(6'd4, W_ADD);
        load(6'd5, W_HLT);
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            stall = vecs[i].stall; ub = vecs[i].ub; br = vecs[i].br; zero = vecs[i].zero;
            #1;
            chk($sformatf("v%0d_pc_pre", i), pc, vecs[i].pc_pre);
            chk($sformatf("v%0d_instr", i), 64'(instruction), 64'(vecs[i].instr_pre));
            chk($sformatf("v%0d_valid", i), 64'(instr_valid), 64'(vecs[i].valid_pre));
            step();
            chk($sformatf("v%0d_pc_post", i), pc, vecs[i].pc_post);
            chk($sformatf("v%0d_cnt", i), 64'(fetch_count), 64'(vecs[i].cnt_post));
            chk($sformatf("v%0d_halted", i), 64'(halted), 64'(vecs[i].halt_post));
        end
        stall = 1'b0; ub = 1'b0; br = 1'b0; zero = 1'b0;

        // Branch to pc == 4*IMEM_DEPTH
        do_reset();
        load(6'd0, W_B64);
        pulse_start();
        ub = 1'b1;
        step();
        ub = 1'b0;
        chk("oor_pc", pc, 64'd256);
        chk("oor_instr", 64'(instruction), 64'd0);
        chk("oor_valid", 64'(instr_valid), 64'd0);
        chk("oor_halted_pre", 64'(halted), 64'd0);
        step();
        chk("oor_halted", 64'(halted), 64'd1);
        chk("oor_cnt", 64'(fetch_count), 64'd1);
        chk("oor_pc_hold", pc, 64'd256);

        // Asynchronous reset mid-run, then rerun with a write attempted in RUN
        do_reset();
        load(6'd0, W_ADD);
        load(6'd1, W_ADD);
        load(6'd2, W_ADD);
        load(6'd3, W_HLT);
        pulse_start();
        step();
        step();
        chk("ar_pc_before", pc, 64'd8);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_pc", pc, 64'd0);
        chk("ar_cnt", 64'(fetch_count), 64'd0);
        chk("ar_valid", 64'(instr_valid), 64'd0);
        step();
        rst = 1'b0;
        pulse_start();
        prog_we = 1'b1; prog_addr = 6'd3; prog_data = W_ADD;
        step();
        prog_we = 1'b0;
        for (int i = 0; i < 50 && !halted; i++) begin
            step();
        end
        chk("rerun_halted", 64'(halted), 64'd1);
        chk("rerun_pc", pc, 64'd12);
        chk("rerun_cnt", 64'(fetch_count), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
